// File: rtl/io_port_hub.sv
// rtl/io_port_hub.sv - memory-mapped byte-stream channels, LED register and key port
module io_port_hub #(
  parameter logic [15:0] BASE       = 16'hFFA0,
  parameter int          CHANNELS   = 2,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 65535,
  parameter int          LED_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           addr,
  input  logic [7:0]            wr_data,
  input  logic                  wren,
  input  logic                  rd,
  output logic [7:0]            rd_data,
  output logic                  hit,
  input  logic [8*CHANNELS-1:0] rx_data,
  input  logic [CHANNELS-1:0]   rx_hit,
  output logic [8*CHANNELS-1:0] cmd_data,
  output logic [CHANNELS-1:0]   cmd_send,
  input  logic [CHANNELS-1:0]   cmd_sent,
  input  logic [CHANNELS-1:0]   cmd_err,
  input  logic [1:0]            keys,
  output logic [LED_W-1:0]      led
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NREG = 4 * CHANNELS + 2;

  typedef enum logic {S_IDLE, S_SEND} cmd_state_e;

  logic [15:0] offset;
  logic [7:0]  head_w   [CHANNELS];
  logic [7:0]  status_w [CHANNELS];
  logic [7:0]  cmd_w    [CHANNELS];
  logic [7:0]  count_w  [CHANNELS];
  logic [LED_W-1:0] led_q;
  logic [7:0]  led_rd;
  logic        led_wr;

  // Offset wraps for addresses below BASE, so the lower bound is checked explicitly.
  assign offset = addr - BASE;
  assign hit    = (addr >= BASE) && (offset < 16'(NREG));
  assign led_wr = hit && wren && (offset == 16'(4 * CHANNELS));
  assign led    = led_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    count_q, count_d;
    cmd_state_e    state_q;
    logic          send_q, cerr_q;
    logic [7:0]    cmd_q;
    logic [15:0]   wdog_q;
    logic          ch_sel, empty, full, pop, push, st_wr, cmd_wr;

    assign ch_sel = hit && (offset[15:2] == 14'(c));
    assign empty  = (level_q == 5'd0);
    assign full   = (level_q == 5'(FIFO_DEPTH));
    assign pop    = ch_sel && (offset[1:0] == 2'd0) && rd && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push   = rx_hit[c] && (!full || pop);
    assign st_wr  = ch_sel && (offset[1:0] == 2'd1) && wren;
    assign cmd_wr = ch_sel && (offset[1:0] == 2'd2) && wren;

    // Next-state for FIFO pointers, fill level, sticky overflow and receive counter.
    always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + 5'(push) - 5'(pop);
      ovf_d    = ovf_q;
      if (st_wr && wr_data[6]) ovf_d = 1'b0;
      if (rx_hit[c] && full && !pop) ovf_d = 1'b1;
      count_d  = count_q + 8'(rx_hit[c]);
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        ovf_q    <= 1'b0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
        ovf_q    <= ovf_d;
        count_q  <= count_d;
      end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rx_data[8*c +: 8];
    end

    // Command send FSM with watchdog; error and timeout take priority over done.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        send_q  <= 1'b0;
        cerr_q  <= 1'b0;
        cmd_q   <= '0;
        wdog_q  <= '0;
      end else begin
        if (st_wr && wr_data[5]) cerr_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            if (cmd_wr) begin
              cmd_q   <= wr_data;
              send_q  <= 1'b1;
              wdog_q  <= '0;
              state_q <= S_SEND;
            end
          end
          S_SEND: begin
            if (cmd_err[c] || (wdog_q == 16'(TIMEOUT - 1))) begin
              cerr_q  <= 1'b1;
              send_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (cmd_sent[c]) begin
              send_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              wdog_q  <= wdog_q + 16'd1;
            end
          end
          default: begin
            send_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end

    assign head_w[c]           = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign status_w[c]         = {send_q, ovf_q, cerr_q, level_q};
    assign cmd_w[c]            = cmd_q;
    assign count_w[c]          = count_q;
    assign cmd_data[8*c +: 8]  = cmd_q;
    assign cmd_send[c]         = send_q;
  end

  // LED output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else if (led_wr) begin
      led_q <= wr_data[LED_W-1:0];
    end
  end

  // Zero-extend the LED register to a full byte for the read path.
  always_comb begin
    led_rd               = '0;
    led_rd[LED_W-1:0]    = led_q;
  end

  // Combinational read mux over all channel and global registers.
  always_comb begin
    rd_data = 8'h00;
    if (hit) begin
      if (offset == 16'(4 * CHANNELS)) begin
        rd_data = led_rd;
      end else if (offset == 16'(4 * CHANNELS + 1)) begin
        rd_data = {6'b0, ~keys};
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (offset[15:2] == 14'(c)) begin
            case (offset[1:0])
              2'd0:    rd_data = head_w[c];
              2'd1:    rd_data = status_w[c];
              2'd2:    rd_data = cmd_w[c];
              default: rd_data = count_w[c];
            endcase
          end
        end
      end
    end
  end

endmodule
